// File: rtl/plc_line_responder.sv
// Parity-protected line store answering PLC read requests through a fixed-latency pipeline.
// Writes can deliberately corrupt one data bit so that the parity checker and error counter can be exercised.
module plc_line_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAY_WIDTH  = 4,
    parameter int DATA_SIZE  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_enable_in,
    input  logic [ADDR_WIDTH-1:0]        addr_in,
    input  logic [WAY_WIDTH-1:0]         way_in,
    input  logic                         write_enable,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [WAY_WIDTH-1:0]         wr_way,
    input  logic [DATA_SIZE-1:0]         data,
    input  logic                         inj_en,
    input  logic [$clog2(DATA_SIZE)-1:0] inj_bit,
    output logic                         rd_valid,
    output logic [DATA_SIZE-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]        addr_out,
    output logic [WAY_WIDTH-1:0]         way_out,
    output logic                         parity_err,
    output logic                         way_err,
    output logic [7:0]                   err_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WI    = (WAY_WIDTH > 1) ? $clog2(WAY_WIDTH) : 1;

    function automatic logic is_onehot(input logic [WAY_WIDTH-1:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [WI-1:0] way_index(input logic [WAY_WIDTH-1:0] v);
        logic [WI-1:0] idx;
        idx = '0;
        for (int i = 0; i < WAY_WIDTH; i++) begin
            if (v[i]) idx = WI'(i);
        end
        return idx;
    endfunction

    // Entry word layout: {parity, data}; the valid bits live in resettable flops.
    logic [DATA_SIZE:0]   mem_q   [DEPTH][WAY_WIDTH];
    logic [WAY_WIDTH-1:0] valid_q [DEPTH];

    logic                 rd_ok, wr_ok;
    logic [DATA_SIZE:0]   rd_word;
    logic                 rd_ent_valid;
    logic [DATA_SIZE-1:0] flip;
    logic [DATA_SIZE:0]   wr_word_d;
    logic [WAY_WIDTH-1:0] valid_row_d;

    logic                 s1_vld_q,  s1_vld_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [WAY_WIDTH-1:0] s1_way_q,  s1_way_d;
    logic [DATA_SIZE:0]   s1_word_q, s1_word_d;
    logic                 s1_ent_q,  s1_ent_d;

    logic                 s2_vld_q,  s2_vld_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [WAY_WIDTH-1:0] s2_way_q,  s2_way_d;
    logic [DATA_SIZE-1:0] s2_data_q, s2_data_d;
    logic                 s2_perr_q, s2_perr_d;

    logic                 rd_valid_q,   rd_valid_d;
    logic [DATA_SIZE-1:0] rd_data_q,    rd_data_d;
    logic [ADDR_WIDTH-1:0] addr_out_q,  addr_out_d;
    logic [WAY_WIDTH-1:0] way_out_q,    way_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 way_err_q,    way_err_d;
    logic [7:0]           err_count_q,  err_count_d;

    always_comb begin
        rd_ok        = read_enable_in && is_onehot(way_in);
        wr_ok        = write_enable && is_onehot(wr_way);
        // Array read sees pre-edge contents, which gives read-before-write on a same-entry collision.
        rd_word      = mem_q[addr_in][way_index(way_in)];
        rd_ent_valid = |(valid_q[addr_in] & way_in);

        flip = '0;
        if (inj_en) flip[inj_bit] = 1'b1;
        wr_word_d   = {^data, data ^ flip};
        valid_row_d = valid_q[wr_addr] | wr_way;

        s1_vld_d  = rd_ok;
        s1_addr_d = addr_in;
        s1_way_d  = way_in;
        s1_word_d = rd_word;
        s1_ent_d  = rd_ent_valid;

        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s2_way_d  = s1_way_q;
        s2_data_d = s1_ent_q ? s1_word_q[DATA_SIZE-1:0] : '0;
        s2_perr_d = s1_ent_q && ((^s1_word_q[DATA_SIZE-1:0]) != s1_word_q[DATA_SIZE]);

        // rd_valid is a single-cycle strobe; data/addr/way hold their last response otherwise.
        rd_valid_d   = s2_vld_q;
        rd_data_d    = s2_vld_q ? s2_data_q : rd_data_q;
        addr_out_d   = s2_vld_q ? s2_addr_q : addr_out_q;
        way_out_d    = s2_vld_q ? s2_way_q  : way_out_q;
        parity_err_d = s2_vld_q && s2_perr_q;
        err_count_d  = (parity_err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;

        way_err_d = (read_enable_in && !is_onehot(way_in)) ||
                    (write_enable && !is_onehot(wr_way));
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_addr][way_index(wr_way)] <= wr_word_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= '0;
        end else if (wr_ok) begin
            valid_q[wr_addr] <= valid_row_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_addr_q    <= '0;
            s1_way_q     <= '0;
            s1_word_q    <= '0;
            s1_ent_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_addr_q    <= '0;
            s2_way_q     <= '0;
            s2_data_q    <= '0;
            s2_perr_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            addr_out_q   <= '0;
            way_out_q    <= '0;
            parity_err_q <= 1'b0;
            way_err_q    <= 1'b0;
            err_count_q  <= 8'h00;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_addr_q    <= s1_addr_d;
            s1_way_q     <= s1_way_d;
            s1_word_q    <= s1_word_d;
            s1_ent_q     <= s1_ent_d;
            s2_vld_q     <= s2_vld_d;
            s2_addr_q    <= s2_addr_d;
            s2_way_q     <= s2_way_d;
            s2_data_q    <= s2_data_d;
            s2_perr_q    <= s2_perr_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            addr_out_q   <= addr_out_d;
            way_out_q    <= way_out_d;
            parity_err_q <= parity_err_d;
            way_err_q    <= way_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign addr_out   = addr_out_q;
    assign way_out    = way_out_q;
    assign parity_err = parity_err_q;
    assign way_err    = way_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_plc_line_responder.sv
// Self-checking bench for plc_line_responder: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model of the line store.
module tb_plc_line_responder;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [7:0]  addr_i;
    logic [3:0]  way_i;
    logic        wr_en;
    logic [7:0]  wr_a;
    logic [3:0]  wr_w;
    logic [63:0] wr_d;
    logic        inj_en;
    logic [5:0]  inj_bit;

    logic        rd_valid;
    logic [63:0] rd_data;
    logic [7:0]  addr_out;
    logic [3:0]  way_out;
    logic        parity_err;
    logic        way_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_err    = 0;

    plc_line_responder #(.ADDR_WIDTH(8), .WAY_WIDTH(4), .DATA_SIZE(64)) dut (
        .clk(clk), .rst(rst),
        .read_enable_in(rd_en), .addr_in(addr_i), .way_in(way_i),
        .write_enable(wr_en), .wr_addr(wr_a), .wr_way(wr_w), .data(wr_d),
        .inj_en(inj_en), .inj_bit(inj_bit),
        .rd_valid(rd_valid), .rd_data(rd_data), .addr_out(addr_out), .way_out(way_out),
        .parity_err(parity_err), .way_err(way_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [63:0] d;
        logic [7:0]  a;
        logic [3:0]  w;
        logic        pe;
    } resp_t;

    resp_t       pq[$];
    resp_t       r;
    logic [63:0] m_data [256][4];
    logic        m_par  [256][4];
    logic        m_val  [256][4];
    int          cyc = 0;

    logic        e_valid = 1'b0;
    logic [63:0] e_data  = '0;
    logic [7:0]  e_addr  = '0;
    logic [3:0]  e_way   = '0;
    logic        e_pe    = 1'b0;
    logic        e_we    = 1'b0;
    logic [7:0]  e_cnt   = '0;

    function automatic int oh_idx(input logic [3:0] w);
        for (int i = 0; i < 4; i++) if (w[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int a = 0; a < 256; a++)
                for (int w = 0; w < 4; w++) m_val[a][w] = 1'b0;
            pq.delete();
            e_valid = 1'b0; e_data = '0; e_addr = '0; e_way = '0;
            e_pe = 1'b0; e_we = 1'b0; e_cnt = '0;
        end else begin
            e_valid = 1'b0;
            e_pe    = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                r = pq.pop_front();
                e_valid = 1'b1;
                e_data  = r.d;
                e_addr  = r.a;
                e_way   = r.w;
                e_pe    = r.pe;
                if (r.pe && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            end
            e_we = (rd_en && $countones(way_i) != 1) || (wr_en && $countones(wr_w) != 1);
            if (rd_en && $countones(way_i) == 1) begin
                r.due = cyc + 2;
                r.a   = addr_i;
                r.w   = way_i;
                if (m_val[addr_i][oh_idx(way_i)]) begin
                    r.d  = m_data[addr_i][oh_idx(way_i)];
                    r.pe = (^r.d) != m_par[addr_i][oh_idx(way_i)];
                end else begin
                    r.d  = '0;
                    r.pe = 1'b0;
                end
                pq.push_back(r);
            end
            if (wr_en && $countones(wr_w) == 1) begin
                m_par[wr_a][oh_idx(wr_w)]  = ^wr_d;
                m_data[wr_a][oh_idx(wr_w)] = inj_en ? (wr_d ^ (64'd1 << inj_bit)) : wr_d;
                m_val[wr_a][oh_idx(wr_w)]  = 1'b1;
            end
        end
    end

    // Per-cycle comparison, well after the edge so model and DUT have both settled.
    always @(posedge clk) begin
        #3;
        check("rd_valid", 64'(rd_valid), 64'(e_valid));
        check("rd_data", rd_data, e_data);
        check("addr_out", 64'(addr_out), 64'(e_addr));
        check("way_out", 64'(way_out), 64'(e_way));
        if (e_valid) check("parity_err", 64'(parity_err), 64'(e_pe));
        check("way_err", 64'(way_err), 64'(e_we));
        check("err_count", 64'(err_count), 64'(e_cnt));
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic re, input logic [7:0] ra, input logic [3:0] rw,
                         input logic we, input logic [7:0] wa, input logic [3:0] ww,
                         input logic [63:0] d, input logic ie, input logic [5:0] ib);
        rd_en = re; addr_i = ra; way_i = rw;
        wr_en = we; wr_a = wa; wr_w = ww; wr_d = d;
        inj_en = ie; inj_bit = ib;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        repeat (n) drive(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 64'h0, 1'b0, 6'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] w, input logic [63:0] d,
                      input logic ie, input logic [5:0] ib);
        drive(1'b0, 8'h00, 4'h0, 1'b1, a, w, d, ie, ib);
    endtask

    task automatic rd(input logic [7:0] a, input logic [3:0] w);
        drive(1'b1, a, w, 1'b0, 8'h00, 4'h0, 64'h0, 1'b0, 6'd0);
    endtask

    function automatic logic [3:0] rnd_way();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
        return 4'(1 << $urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1;
        rd_en = 1'b0; addr_i = '0; way_i = '0;
        wr_en = 1'b0; wr_a = '0; wr_w = '0; wr_d = '0;
        inj_en = 1'b0; inj_bit = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_err_count", 64'(err_count), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        nop(1);

        // Basic write then read, two-edge latency.
        wr(8'h55, 4'b0001, 64'h0123_4567_89AB_CDEF, 1'b0, 6'd0);
        rd(8'h55, 4'b0001);
        nop(1);
        check("basic_early_valid", 64'(rd_valid), 64'd0);
        nop(1);
        check("basic_valid", 64'(rd_valid), 64'd1);
        check("basic_data", rd_data, 64'h0123_4567_89AB_CDEF);
        check("basic_perr", 64'(parity_err), 64'd0);
        check("basic_addr", 64'(addr_out), 64'h55);
        check("basic_way", 64'(way_out), 64'b0001);
        nop(1);
        check("basic_pulse_end", 64'(rd_valid), 64'd0);
        check("basic_hold", rd_data, 64'h0123_4567_89AB_CDEF);

        // Fault injection on bit 0.
        wr(8'hAA, 4'b0100, 64'hFEDC_BA98_7654_3210, 1'b1, 6'd0);
        rd(8'hAA, 4'b0100);
        nop(2);
        check("inj_data", rd_data, 64'hFEDC_BA98_7654_3211);
        check("inj_perr", 64'(parity_err), 64'd1);
        check("inj_count", 64'(err_count), 64'd1);

        // Back-to-back reads including an unwritten entry.
        wr(8'h12, 4'b0010, 64'h1111_2222_3333_4444, 1'b0, 6'd0);
        wr(8'h34, 4'b1000, 64'h5555_6666_7777_8888, 1'b0, 6'd0);
        rd(8'h12, 4'b0010);
        rd(8'h34, 4'b1000);
        rd(8'h56, 4'b0001);
        check("b2b_0_addr", 64'(addr_out), 64'h12);
        check("b2b_0_data", rd_data, 64'h1111_2222_3333_4444);
        nop(1);
        check("b2b_1_valid", 64'(rd_valid), 64'd1);
        check("b2b_1_data", rd_data, 64'h5555_6666_7777_8888);
        nop(1);
        check("b2b_2_valid", 64'(rd_valid), 64'd1);
        check("b2b_2_addr", 64'(addr_out), 64'h56);
        check("b2b_2_data", rd_data, 64'd0);
        check("b2b_2_perr", 64'(parity_err), 64'd0);

        // Read-before-write collision, then the following read sees new data.
        wr(8'h77, 4'b0001, 64'hAAAA_0000_AAAA_0000, 1'b0, 6'd0);
        drive(1'b1, 8'h77, 4'b0001, 1'b1, 8'h77, 4'b0001, 64'h0000_BBBB_0000_BBBB, 1'b0, 6'd0);
        rd(8'h77, 4'b0001);
        nop(1);
        check("rbw_old", rd_data, 64'hAAAA_0000_AAAA_0000);
        nop(1);
        check("rbw_new", rd_data, 64'h0000_BBBB_0000_BBBB);

        // Illegal ways on both ports at once.
        drive(1'b1, 8'h12, 4'b0011, 1'b1, 8'h12, 4'b0000, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 6'd0);
        check("wayerr_pulse", 64'(way_err), 64'd1);
        nop(1);
        check("wayerr_end", 64'(way_err), 64'd0);
        nop(1);
        check("wayerr_no_valid", 64'(rd_valid), 64'd0);
        rd(8'h12, 4'b0010);
        nop(2);
        check("wayerr_unchanged", rd_data, 64'h1111_2222_3333_4444);

        // Random traffic on a small address window so collisions are frequent.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), rnd_way(),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), rnd_way(),
                  {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)));
        end
        nop(3);

        // Saturate the error counter.
        wr(8'hC0, 4'b0001, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 6'd5);
        for (int i = 0; i < 300; i++) rd(8'hC0, 4'b0001);
        nop(3);
        check("sat_count", 64'(err_count), 64'hFF);

        // Reset one cycle after a read: the read is dropped and contents are masked.
        wr(8'h99, 4'b0001, 64'h1234_5678_9ABC_DEF0, 1'b0, 6'd0);
        rd(8'h99, 4'b0001);
        rst = 1'b1;
        nop(3);
        rst = 1'b0;
        nop(4);
        check("rst_count", 64'(err_count), 64'd0);
        check("rst_no_valid", 64'(rd_valid), 64'd0);
        rd(8'h99, 4'b0001);
        nop(2);
        check("rst_rd_valid", 64'(rd_valid), 64'd1);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_rd_perr", 64'(parity_err), 64'd0);
        nop(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
